fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction fetch stage that sits directly upstream of the program ROM.
- Holds the program counter and issues word reads to the ROM (1-cycle synchronous read latency).
- Buffers the returned instructions with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects: flushes buffered instructions and drops any in-flight read.

Parameters:
- ADDR_WIDTH, 16, ROM word-address width; ROM covers 2^ADDR_WIDTH 32-bit words.
- RESET_PC, 32'h0000_0000, byte PC loaded at reset; bits [1:0] are ignored.
- FIFO_DEPTH, 2, instruction buffer entries; legal values are 2 or 4.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset.
- rom_ce  out  1  ROM read enable for this cycle.
- rom_addr  out  ADDR_WIDTH  ROM word address; equals fetch_pc[ADDR_WIDTH+1:2].
- rom_rdata  in  32  ROM read data; valid the cycle after rom_ce.
- rom_rdata_valid  in  1  ROM read-data-valid strobe.
- redirect_valid  in  1  one-cycle request to change the fetch PC.
- redirect_pc  in  32  new byte PC; bits [1:0] are forced to 0.
- inst_valid  out  1  FIFO head is valid.
- inst_data  out  32  instruction at the FIFO head.
- inst_pc  out  32  byte PC of the FIFO head.
- inst_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- The top level drives ROM rst_n = ~rst.

Reset:
- Applies on the clk edge when rst=1. It sets fetch_pc=RESET_PC with [1:0]=0, FIFO empty, inflight=0, kill=0.
- While rst=1, rom_ce=0 and inst_valid=0.
- inst_data and inst_pc reset to 32'h0000_0013 and 0 respectively.

State:
- fetch_pc (32b).
- inflight (1b): a read was issued last cycle.
- inflight_pc (32b).
- kill (1b): drop the next ROM response.
- FIFO of {pc, inst} entries with an occupancy count.

Pop:
- pop = inst_valid && inst_ready.
- inst_valid = (count != 0). inst_data and inst_pc are the head entry, driven combinationally from FIFO storage.

Issue:
- rom_ce = !rst && !redirect_valid && (inflight + count - pop < FIFO_DEPTH).
- The path from inst_ready to rom_ce is combinational by design.
- On an issue: inflight <= 1, inflight_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (modulo 2^32). Otherwise inflight <= 0.

Response:
- When inflight && rom_rdata_valid && !kill && !redirect_valid, push {inflight_pc, rom_rdata}.
- A response with inflight=0 is ignored.

Credit and overflow:
- The credit rule guarantees a push never meets a full FIFO.
- Simultaneous push and pop in the same cycle leave count unchanged.
- Push into an empty FIFO makes inst_valid=1 the next cycle; there is no bypass.

Latency and throughput:
- Issue in cycle N, ROM data in N+1, inst_valid in N+2.
- Sustained throughput is 1 instruction/cycle while inst_ready=1.

Redirect (priority over all other events in the cycle):
- fetch_pc <= {redirect_pc[31:2], 2'b00}.
- FIFO is emptied; a pop in the same cycle is still a valid handshake of the old head.
- Any push this cycle is discarded; rom_ce=0.
- kill <= inflight. This covers a read issued in the redirect cycle's predecessor that returns next cycle.
- kill clears after one cycle.
- The first fetch from the new PC issues the cycle after the redirect.
- Back-to-back redirects: the last one wins.

Wrap-around:
- fetch_pc wraps 32'hFFFF_FFFC -> 0.
- rom_addr aliases modulo ROM size; no error is signalled.

Stall:
- With inst_ready=0 the FIFO fills to FIFO_DEPTH, then rom_ce stays 0.
- Head contents are held stable while inst_valid=1 and inst_ready=0.

Test Plan:
1. Reset then inst_ready=1, ROM words 0..3 = 0x11,0x22,0x33,0x44 -> first rom_ce in the first cycle after rst falls, addr 0. inst_valid rises 2 cycles later; outputs (pc,inst) = (0,0x11),(4,0x22),(8,0x33),(C,0x44) on consecutive cycles.
2. inst_ready=0 from reset -> exactly 2 reads issued (addr 0,1), then rom_ce=0. Head holds (0,0x11). Raising inst_ready drains both, then fetching resumes at addr 2 with no gap in inst_valid beyond 2 cycles.
3. redirect_valid with redirect_pc=0x0000_0102 while streaming -> FIFO empties and the in-flight word is dropped. The next rom_addr is 0x40 and the next delivered inst_pc is 0x100; no old-PC instruction appears after the redirect.
4. Redirects on two consecutive cycles to 0x20 then 0x80 -> the only delivered PCs after the redirects start at 0x80.
5. RESET_PC=32'hFFFF_FFF8, ADDR_WIDTH=4 -> delivered PCs are FFFF_FFF8, FFFF_FFFC, 0, 4; rom_addr sequence is E, F, 0, 1.
6. rst asserted mid-stream with a full FIFO -> next cycle inst_valid=0 and rom_ce=0. After rst falls, fetch restarts at RESET_PC and the pre-reset in-flight data never appears.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: PC generation, ROM word reads and a small {pc, inst} buffer
// feeding decode over valid/ready, with redirect flush and response kill.
module fetch_unit #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  rom_ce,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_rst_n,
   input  logic [31:0]           rom_rdata,
   input  logic                  rom_rdata_valid,
   input  logic                  redirect_valid,
   input  logic [31:0]           redirect_pc,
   output logic                  inst_valid,
   output logic [31:0]           inst_data,
   output logic [31:0]           inst_pc,
   input  logic                  inst_ready
);

   localparam int unsigned PW = (FIFO_DEPTH > 2) ? 2 : 1;
   localparam int unsigned CW = PW + 1;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          inflight_q, inflight_d;
   logic [31:0]   inflight_pc_q, inflight_pc_d;
   logic          kill_q, kill_d;
   logic [CW-1:0] count_q, count_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [PW-1:0] wr_q, wr_d;
   logic [31:0]   pc_q   [FIFO_DEPTH];
   logic [31:0]   inst_q [FIFO_DEPTH];

   logic          pop;
   logic          push;
   logic [CW:0]   occ;
   logic          unused_bits;

   assign unused_bits = ^{fetch_pc_q[1:0], redirect_pc[1:0]};

   assign rom_rst_n  = ~rst;
   assign rom_addr   = fetch_pc_q[ADDR_WIDTH+1:2];
   assign inst_valid = !rst && (count_q != '0);
   assign inst_data  = inst_q[rd_q];
   assign inst_pc    = pc_q[rd_q];
   assign pop        = inst_valid && inst_ready;

   // Credit check: outstanding read plus buffered entries must leave room.
   always_comb begin
      occ    = {{CW{1'b0}}, inflight_q} + {1'b0, count_q}
             - {{CW{1'b0}}, pop};
      rom_ce = !rst && !redirect_valid && (occ < DEPTH_C);
      push   = inflight_q && rom_rdata_valid && !kill_q && !redirect_valid;
   end

   // Next-state: redirect overrides issue, push and pop bookkeeping.
   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      kill_d        = 1'b0;
      count_d       = count_q;
      rd_d          = rd_q;
      wr_d          = wr_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         kill_d     = inflight_q;
         count_d    = '0;
         rd_d       = '0;
         wr_d       = '0;
      end else begin
         if (rom_ce) begin
            inflight_d    = 1'b1;
            inflight_pc_d = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
         end
         if (push) wr_d = wr_q + PW'(1);
         if (pop)  rd_d = rd_q + PW'(1);
         unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= {RESET_PC[31:2], 2'b00};
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
         kill_q        <= 1'b0;
         count_q       <= '0;
         rd_q          <= '0;
         wr_q          <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
         kill_q        <= kill_d;
         count_q       <= count_d;
         rd_q          <= rd_d;
         wr_q          <= wr_d;
      end
   end

   // Buffer storage: written on push, reset to a NOP at pc 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            pc_q[i]   <= '0;
            inst_q[i] <= NOP;
         end
      end else if (push) begin
         pc_q[wr_q]   <= inflight_pc_q;
         inst_q[wr_q] <= rom_rdata;
      end
   end

endmodule
